ad9226_capture_ctrl: RTL

- Sequencer for one AD9226 ADC interface channel.
- Generates the ADC sample clock from the system clock with a programmable divider.
- Frames the interface's end-of-conversion sample stream into fixed-length AXI-Stream packets in single-shot or continuous mode.
- Sits between the AD9226 interface block and the DMA/AXIS fabric; software controls it through the cfg_* and start/abort ports.

---
 rtl/ad9226_capture_ctrl_if.sv | 13 +
 rtl/ad9226_capture_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/ad9226_capture_ctrl_if.sv
// AXI-Stream sample output of the AD9226 capture sequencer.
// The master side drives tdata/tvalid/tlast; the slave side returns tready.
interface ad9226_capture_ctrl_if #(
  parameter int DATA_WIDTH = 12
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/ad9226_capture_ctrl.sv
// AD9226 channel sequencer: sample-clock divider plus AXIS frame builder (adc_eoc -> tvalid in 1 cycle).
// Optional level trigger arming with macro AD9226_CAPTURE_CTRL_TRIG_LEVEL_EN; samples are dropped (sticky overflow) under backpressure.
module ad9226_capture_ctrl #(
  parameter int ADC_DATA_WIDTH = 12,
  parameter int DIV_WIDTH      = 16,
  parameter int LEN_WIDTH      = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DIV_WIDTH-1:0]             cfg_div,
  input  logic [LEN_WIDTH-1:0]             cfg_frame_len,
  input  logic                             cfg_continuous,
  input  logic                             start,
  input  logic                             abort,
  output logic                             clk_sample,
  input  logic                             adc_eoc,
  input  logic signed [ADC_DATA_WIDTH-1:0] adc_data,
`ifdef AD9226_CAPTURE_CTRL_TRIG_LEVEL_EN
  input  logic signed [ADC_DATA_WIDTH-1:0] trig_level,
`endif
  ad9226_capture_ctrl_if.master            m_axis,
  output logic                             busy,
  output logic                             overflow
);

  typedef enum logic [1:0] {IDLE, WAIT_ALIGN, CAPTURE, FLUSH} state_t;

  state_t                      state_q;
  logic [DIV_WIDTH-1:0]        div_cnt_q, div_cnt_d, div_q, div_eff, div_use;
  logic                        div_wrap, clk_sample_q, clk_sample_d;
  logic [LEN_WIDTH-1:0]        smp_cnt_q, len_q;
  logic                        cont_q, tvalid_q, tlast_q, overflow_q;
  logic [ADC_DATA_WIDTH-1:0]   tdata_q;
  logic                        take_smp, can_load, smp_last, wait_take;

  // The period length is sampled at count 0 and held for the rest of that period.
  assign div_eff      = (cfg_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : cfg_div;
  assign div_use      = (div_cnt_q == '0) ? div_eff : div_q;
  assign div_wrap     = (div_cnt_q == div_use - DIV_WIDTH'(1));
  assign div_cnt_d    = div_wrap ? '0 : div_cnt_q + DIV_WIDTH'(1);
  assign clk_sample_d = (div_cnt_d == '0) || (div_cnt_d < (div_use >> 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q    <= '0;
      div_q        <= DIV_WIDTH'(2);
      clk_sample_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      clk_sample_q <= clk_sample_d;
      if (div_cnt_q == '0) div_q <= div_eff;
    end
  end

`ifdef AD9226_CAPTURE_CTRL_TRIG_LEVEL_EN
  localparam logic signed [ADC_DATA_WIDTH-1:0] PREV_MIN = {1'b1, {(ADC_DATA_WIDTH-1){1'b0}}};
  logic signed [ADC_DATA_WIDTH-1:0] prev_q;

  assign wait_take = (state_q == WAIT_ALIGN) && adc_eoc &&
                     (prev_q < trig_level) && (adc_data >= trig_level);
`else
  assign wait_take = 1'b0;
`endif

  assign take_smp = (adc_eoc && (state_q == CAPTURE)) || wait_take;
  assign can_load = !tvalid_q || m_axis.tready;
  assign smp_last = ((smp_cnt_q + LEN_WIDTH'(1)) == len_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      smp_cnt_q  <= '0;
      len_q      <= LEN_WIDTH'(1);
      cont_q     <= 1'b0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      overflow_q <= 1'b0;
`ifdef AD9226_CAPTURE_CTRL_TRIG_LEVEL_EN
      prev_q     <= PREV_MIN;
`endif
    end else begin
      if (tvalid_q && m_axis.tready) begin
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
      end
      if (abort) begin
        // Pending beat is discarded; overflow is left for software to read.
        state_q  <= IDLE;
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              len_q      <= (cfg_frame_len == '0) ? LEN_WIDTH'(1) : cfg_frame_len;
              cont_q     <= cfg_continuous;
              overflow_q <= 1'b0;
              smp_cnt_q  <= '0;
              state_q    <= WAIT_ALIGN;
`ifdef AD9226_CAPTURE_CTRL_TRIG_LEVEL_EN
              prev_q     <= PREV_MIN;
`endif
            end
          end
          WAIT_ALIGN: begin
`ifdef AD9226_CAPTURE_CTRL_TRIG_LEVEL_EN
            if (adc_eoc) prev_q <= adc_data;
`else
            if (div_wrap) state_q <= CAPTURE;
`endif
          end
          FLUSH: begin
            if (tvalid_q && m_axis.tready && tlast_q) begin
              if (cont_q) begin
                smp_cnt_q <= '0;
                state_q   <= WAIT_ALIGN;
`ifdef AD9226_CAPTURE_CTRL_TRIG_LEVEL_EN
                prev_q    <= PREV_MIN;
`endif
              end else begin
                state_q <= IDLE;
              end
            end
          end
          default: ;
        endcase

        // Sample acceptance; overrides the handshake clear when a new beat lands.
        if (take_smp) begin
          if (can_load) begin
            tdata_q   <= adc_data;
            tvalid_q  <= 1'b1;
            tlast_q   <= smp_last;
            smp_cnt_q <= smp_cnt_q + LEN_WIDTH'(1);
            state_q   <= smp_last ? FLUSH : CAPTURE;
          end else begin
            overflow_q <= 1'b1;
          end
        end
      end
    end
  end

  assign clk_sample    = clk_sample_q;
  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign busy          = (state_q != IDLE);
  assign overflow      = overflow_q;

endmodule
